assoc_lookup_bank: RTL and testbench

Parametrised fully-associative key/data bank with per-entry valid bits, true-LRU replacement, update-in-place on key match, global invalidate and same-cycle write-to-read forwarding. It is the general lookup storage used by the MIPS core's small associative structures (branch target / victim style tables). Lookups return a registered result with a hit flag one cycle after the key is presented.

---
 rtl/assoc_lookup_pkg.sv | 17 +
 rtl/assoc_lookup_bank_lru.sv | 58 +++++
 rtl/assoc_lookup_bank.sv | 154 +++++++++++++++
 tb/tb_assoc_lookup_bank.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_lookup_pkg.sv
// Shared types and helpers for the associative lookup bank and its LRU tracker.
package assoc_lookup_pkg;

    // Where a write lands: on the entry already holding its key, on a free
    // entry, or on the least recently used entry.
    typedef enum logic [1:0] {
        VICTIM_MATCH,
        VICTIM_FREE,
        VICTIM_LRU
    } victim_src_e;

    // Width of an age counter / entry index; never narrower than one bit.
    function automatic int calcAgeWidth(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/assoc_lookup_bank_lru.sv
// True-LRU age tracker: one age per entry, ages always a permutation of
// 0..DEPTH-1 with 0 = most recently used and DEPTH-1 = least recently used.
module lru_age_tracker
    import assoc_lookup_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = calcAgeWidth(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          touchEn_i,
    input  logic [AW-1:0] touchIdx_i,
    output logic [AW-1:0] lruIdx_o
);

    logic [AW-1:0] age_q [DEPTH];
    logic [AW-1:0] age_d [DEPTH];
    logic [AW-1:0] touchedAge;

    // Touching an entry makes it MRU and ages everything that was younger than it.
    always_comb begin
        touchedAge = age_q[touchIdx_i];
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
            if (touchEn_i) begin
                if (AW'(i) == touchIdx_i) begin
                    age_d[i] = '0;
                end else if (age_q[i] < touchedAge) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    // Exactly one entry carries the oldest age; report its index.
    always_comb begin
        lruIdx_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_q[i] == AW'(DEPTH - 1)) begin
                lruIdx_o = AW'(i);
            end
        end
    end

    // Age register; reset seeds the identity permutation so entry 0 starts as MRU.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= AW'(i);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: rtl/assoc_lookup_bank.sv
// Fully-associative key/data bank with valid bits, true-LRU replacement,
// update-in-place on key match, global invalidate and write-to-read forwarding.
// Lookup results are registered and appear one cycle after the key.
module assoc_lookup_bank
    import assoc_lookup_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [KEY_WIDTH-1:0]  i_wkey,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [KEY_WIDTH-1:0]  i_rkey,
    input  logic                  i_inv,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_hit,
    output logic                  o_full
);

    localparam int AW = calcAgeWidth(DEPTH);
    typedef logic [AW-1:0] idx_t;

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [KEY_WIDTH-1:0]  key_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  hit_q;
    logic                  hit_d;
    logic                  full_q;

    logic [DEPTH-1:0]      rMatch;
    logic [DEPTH-1:0]      wMatch;
    logic [DEPTH-1:0]      validEff;
    logic [DATA_WIDTH-1:0] rMatchData;
    idx_t                  rMatchIdx;
    idx_t                  wMatchIdx;
    idx_t                  freeIdx;
    idx_t                  lruIdx;
    idx_t                  victimIdx;
    idx_t                  touchIdx;
    logic                  freeFound;
    logic                  touchEn;
    logic                  forward;
    victim_src_e           victimSrc;

    // Compare both keys against every valid entry; keys are unique so at most one matches.
    always_comb begin
        rMatch     = '0;
        wMatch     = '0;
        rMatchIdx  = '0;
        wMatchIdx  = '0;
        rMatchData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rMatch[i] = valid_q[i] && (key_q[i] == i_rkey);
            wMatch[i] = valid_q[i] && (key_q[i] == i_wkey);
            if (rMatch[i]) begin
                rMatchIdx  = idx_t'(i);
                rMatchData = data_q[i];
            end
            if (wMatch[i]) begin
                wMatchIdx = idx_t'(i);
            end
        end
    end

    // Victim choice sees the array after invalidate: existing key, then lowest free, then LRU.
    always_comb begin
        validEff  = i_inv ? '0 : valid_q;
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!validEff[i]) begin
                freeFound = 1'b1;
                freeIdx   = idx_t'(i);
            end
        end
        if (!i_inv && (|wMatch)) begin
            victimSrc = VICTIM_MATCH;
        end else if (freeFound) begin
            victimSrc = VICTIM_FREE;
        end else begin
            victimSrc = VICTIM_LRU;
        end
        case (victimSrc)
            VICTIM_MATCH: victimIdx = wMatchIdx;
            VICTIM_FREE:  victimIdx = freeIdx;
            default:      victimIdx = lruIdx;
        endcase
    end

    // Lookup result, recency update and next valid bits; a write owns the touch port.
    always_comb begin
        forward = i_we && (i_wkey == i_rkey);
        hit_d   = 1'b0;
        rdata_d = '0;
        if (forward) begin
            hit_d   = 1'b1;
            rdata_d = i_wdata;
        end else if (!i_inv && (|rMatch)) begin
            hit_d   = 1'b1;
            rdata_d = rMatchData;
        end
        touchEn  = i_we || (!i_inv && (|rMatch));
        touchIdx = i_we ? victimIdx : rMatchIdx;
        valid_d  = validEff;
        if (i_we) begin
            valid_d[victimIdx] = 1'b1;
        end
    end

    lru_age_tracker #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_lru (
        .clk        (clk),
        .rst        (rst),
        .touchEn_i  (touchEn),
        .touchIdx_i (touchIdx),
        .lruIdx_o   (lruIdx)
    );

    // Entry storage and registered lookup outputs; reset wins over every request.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
            rdata_q <= '0;
            hit_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (i_we) begin
                key_q[victimIdx]  <= i_wkey;
                data_q[victimIdx] <= i_wdata;
            end
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
            full_q  <= &valid_d;
        end
    end

    assign o_rdata = rdata_q;
    assign o_hit   = hit_q;
    assign o_full  = full_q;

endmodule

// File: tb/tb_assoc_lookup_bank.sv
// Self-checking bench for assoc_lookup_bank: a directed vector table, hand
// sequences for fill/evict/invalidate corners, and a random stream on a
// 16-entry and a 4-entry bank compared against a recency-list model.
module tb_assoc_lookup_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        we = 1'b0;
    logic [4:0]  wkey = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  rkey = '0;
    logic        inv = 1'b0;
    logic [31:0] rdata;
    logic        hit;
    logic        full;

    logic        we4 = 1'b0;
    logic [2:0]  wkey4 = '0;
    logic [31:0] wdata4 = '0;
    logic [2:0]  rkey4 = '0;
    logic        inv4 = 1'b0;
    logic [31:0] rdata4;
    logic        hit4;
    logic        full4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assoc_lookup_bank #(.DATA_WIDTH(32), .KEY_WIDTH(5), .DEPTH(16)) dut16 (
        .clk(clk), .rst(rst), .i_we(we), .i_wkey(wkey), .i_wdata(wdata),
        .i_rkey(rkey), .i_inv(inv), .o_rdata(rdata), .o_hit(hit), .o_full(full)
    );

    assoc_lookup_bank #(.DATA_WIDTH(32), .KEY_WIDTH(3), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .i_we(we4), .i_wkey(wkey4), .i_wdata(wdata4),
        .i_rkey(rkey4), .i_inv(inv4), .o_rdata(rdata4), .o_hit(hit4), .o_full(full4)
    );

    // Reference model: per-entry contents plus a recency list (index 0 = MRU).
    bit          mValid [2][16];
    int          mKey   [2][16];
    logic [31:0] mData  [2][16];
    int          mOrder [2][16];

    task automatic modelReset(input int m);
        for (int e = 0; e < 16; e++) begin
            mValid[m][e] = 1'b0;
            mKey[m][e]   = 0;
            mData[m][e]  = '0;
            mOrder[m][e] = e;
        end
    endtask

    task automatic modelTouch(input int m, input int depth, input int e);
        int p;
        p = 0;
        for (int q = 0; q < depth; q++) begin
            if (mOrder[m][q] == e) p = q;
        end
        for (int q = p; q > 0; q--) begin
            mOrder[m][q] = mOrder[m][q-1];
        end
        mOrder[m][0] = e;
    endtask

    task automatic modelStep(input int m, input int depth, input bit mwe, input int mwkey,
                             input logic [31:0] mwdata, input int mrkey, input bit minv,
                             output bit eHit, output logic [31:0] eData, output bit eFull);
        int hitEnt;
        int victim;
        hitEnt = -1;
        victim = -1;
        for (int e = 0; e < depth; e++) begin
            if (mValid[m][e] && mKey[m][e] == mrkey) hitEnt = e;
        end
        if (mwe && mwkey == mrkey) begin
            eHit = 1'b1;
            eData = mwdata;
        end else if (!minv && hitEnt >= 0) begin
            eHit = 1'b1;
            eData = mData[m][hitEnt];
        end else begin
            eHit = 1'b0;
            eData = '0;
        end
        if (minv) begin
            for (int e = 0; e < depth; e++) mValid[m][e] = 1'b0;
        end
        if (mwe) begin
            for (int e = 0; e < depth; e++) begin
                if (mValid[m][e] && mKey[m][e] == mwkey) victim = e;
            end
            if (victim < 0) begin
                for (int e = depth - 1; e >= 0; e--) begin
                    if (!mValid[m][e]) victim = e;
                end
            end
            if (victim < 0) victim = mOrder[m][depth-1];
            mValid[m][victim] = 1'b1;
            mKey[m][victim]   = mwkey;
            mData[m][victim]  = mwdata;
            modelTouch(m, depth, victim);
        end else if (!minv && hitEnt >= 0) begin
            modelTouch(m, depth, hitEnt);
        end
        eFull = 1'b1;
        for (int e = 0; e < depth; e++) begin
            if (!mValid[m][e]) eFull = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic aHit, input logic [31:0] aData,
                               input logic aFull, input logic eHit, input logic [31:0] eData,
                               input logic eFull);
        vectors++;
        if (aHit !== eHit || aData !== eData || aFull !== eFull) begin
            miscompares++;
            $display("[TB] FAIL %s: got hit=%0b data=%h full=%0b, expected hit=%0b data=%h full=%0b",
                     name, aHit, aData, aFull, eHit, eData, eFull);
        end
    endtask

    // Drive one cycle of the 16-entry bank and land #1 after the sampling edge.
    task automatic applyStimulus(input bit sWe, input int sWkey, input logic [31:0] sWdata,
                                 input int sRkey, input bit sInv);
        we    = sWe;
        wkey  = 5'(sWkey);
        wdata = sWdata;
        rkey  = 5'(sRkey);
        inv   = sInv;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string name);
        rst = 1'b1;
        we = 1'b1; wkey = 5'd3; wdata = 32'hDEAD_BEEF; rkey = 5'd3; inv = 1'b0;
        we4 = 1'b0; inv4 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput(name, hit, rdata, full, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        we = 1'b0;
        modelReset(0);
        modelReset(1);
    endtask

    typedef struct {
        bit          we;
        int          wkey;
        logic [31:0] wdata;
        int          rkey;
        bit          inv;
        logic        expHit;
        logic [31:0] expData;
        logic        expFull;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bit          eHit;
        logic [31:0] eData;
        bit          eFull;
        bit          eHit4;
        logic [31:0] eData4;
        bit          eFull4;
        bit          rWe;
        bit          rInv;
        int          rWkey;
        int          rRkey;
        logic [31:0] rWdata;
        bit          rWe4;
        bit          rInv4;
        int          rWkey4;
        int          rRkey4;
        logic [31:0] rWdata4;

        vecs[0] = '{0, 0, 32'h0,      3, 0, 0, 32'h0,      0};
        vecs[1] = '{1, 5, 32'hAAAA,   3, 0, 0, 32'h0,      0};
        vecs[2] = '{0, 0, 32'h0,      5, 0, 1, 32'hAAAA,   0};
        vecs[3] = '{1, 7, 32'h1234,   7, 0, 1, 32'h1234,   0};
        vecs[4] = '{0, 0, 32'h0,      7, 0, 1, 32'h1234,   0};
        vecs[5] = '{0, 0, 32'h0,      6, 0, 0, 32'h0,      0};
        vecs[6] = '{1, 5, 32'hBBBB,   5, 0, 1, 32'hBBBB,   0};
        vecs[7] = '{0, 0, 32'h0,      5, 0, 1, 32'hBBBB,   0};
        vecs[8] = '{0, 0, 32'h0,      5, 1, 0, 32'h0,      0};
        vecs[9] = '{0, 0, 32'h0,      7, 0, 0, 32'h0,      0};

        doReset("reset");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].we, vecs[i].wkey, vecs[i].wdata, vecs[i].rkey, vecs[i].inv);
            checkOutput($sformatf("table %0d", i), hit, rdata, full,
                        vecs[i].expHit, vecs[i].expData, vecs[i].expFull);
        end

        // Fill 16 keys, then rewrite key 4 in place: no duplicate means key 0 is never evicted.
        doReset("reset before fill");
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1, k, 32'h100 + k, 31, 0);
            checkOutput($sformatf("fill %0d", k), hit, rdata, full, 1'b0, 32'h0, k == 15);
        end
        applyStimulus(1, 4, 32'hBEEF, 31, 0);
        applyStimulus(0, 0, 32'h0, 4, 0);
        checkOutput("rewrite key4", hit, rdata, full, 1'b1, 32'hBEEF, 1'b1);
        applyStimulus(0, 0, 32'h0, 0, 0);
        checkOutput("no duplicate key0", hit, rdata, full, 1'b1, 32'h100, 1'b1);
        applyStimulus(0, 0, 32'h0, 15, 0);
        checkOutput("no duplicate key15", hit, rdata, full, 1'b1, 32'h10F, 1'b1);

        // Fill, hit key 0 so key 1 becomes LRU, then a new key must evict key 1.
        doReset("reset before evict");
        for (int k = 0; k < 16; k++) applyStimulus(1, k, 32'h200 + k, 31, 0);
        applyStimulus(0, 0, 32'h0, 0, 0);
        checkOutput("touch key0", hit, rdata, full, 1'b1, 32'h200, 1'b1);
        applyStimulus(1, 16, 32'h1616, 30, 0);
        applyStimulus(0, 0, 32'h0, 1, 0);
        checkOutput("evicted key1", hit, rdata, full, 1'b0, 32'h0, 1'b1);
        applyStimulus(0, 0, 32'h0, 0, 0);
        checkOutput("kept key0", hit, rdata, full, 1'b1, 32'h200, 1'b1);
        applyStimulus(0, 0, 32'h0, 16, 0);
        checkOutput("new key16", hit, rdata, full, 1'b1, 32'h1616, 1'b1);
        applyStimulus(0, 0, 32'h0, 2, 0);
        checkOutput("kept key2", hit, rdata, full, 1'b1, 32'h202, 1'b1);

        // Fill, then invalidate together with a write: only the new key survives.
        doReset("reset before inv");
        for (int k = 0; k < 16; k++) applyStimulus(1, k, 32'h300 + k, 31, 0);
        applyStimulus(1, 9, 32'h55, 9, 1);
        checkOutput("inv+write fwd", hit, rdata, full, 1'b1, 32'h55, 1'b0);
        applyStimulus(0, 0, 32'h0, 9, 0);
        checkOutput("inv key9 stored", hit, rdata, full, 1'b1, 32'h55, 1'b0);
        applyStimulus(0, 0, 32'h0, 3, 0);
        checkOutput("inv key3 gone", hit, rdata, full, 1'b0, 32'h0, 1'b0);
        applyStimulus(0, 0, 32'h0, 0, 0);
        checkOutput("inv key0 gone", hit, rdata, full, 1'b0, 32'h0, 1'b0);

        // Random stream on both banks against the model, with occasional mid-stream reset.
        doReset("reset before random");
        for (int c = 0; c < 10000; c++) begin
            rWe    = ($urandom_range(0, 99) < 60);
            rInv   = ($urandom_range(0, 63) == 0);
            rWkey  = $urandom_range(0, 23);
            rRkey  = $urandom_range(0, 23);
            rWdata = $urandom;
            rWe4    = ($urandom_range(0, 99) < 55);
            rInv4   = ($urandom_range(0, 47) == 0);
            rWkey4  = $urandom_range(0, 7);
            rRkey4  = $urandom_range(0, 7);
            rWdata4 = $urandom;
            we = rWe; inv = rInv; wkey = 5'(rWkey); rkey = 5'(rRkey); wdata = rWdata;
            we4 = rWe4; inv4 = rInv4; wkey4 = 3'(rWkey4); rkey4 = 3'(rRkey4); wdata4 = rWdata4;
            if (c % 2500 == 1249) begin
                rst = 1'b1;
                modelReset(0);
                modelReset(1);
                eHit = 0; eData = '0; eFull = 0;
                eHit4 = 0; eData4 = '0; eFull4 = 0;
            end else begin
                rst = 1'b0;
                modelStep(0, 16, rWe, rWkey, rWdata, rRkey, rInv, eHit, eData, eFull);
                modelStep(1, 4, rWe4, rWkey4, rWdata4, rRkey4, rInv4, eHit4, eData4, eFull4);
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("rand16 cyc %0d", c), hit, rdata, full, eHit, eData, eFull);
            checkOutput($sformatf("rand4 cyc %0d", c), hit4, rdata4, full4, eHit4, eData4, eFull4);
        end
        rst = 1'b0;
        we = 1'b0;
        we4 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
